// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter sequencer and its return-address stack.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } pc_state_e;

  localparam int unsigned DEF_STACK_DEPTH = 4;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_stack.sv
// Return-address LIFO with a registered top entry and registered empty/full flags.
// Overflow/underflow are not checked here; the sequencer never pushes when full or pops when empty.
module pc_stack
  import pc_pkg::*;
#(
  parameter int unsigned PC_W        = 11,
  parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [PC_W-1:0] i_push_data,
  output logic [PC_W-1:0] o_top,
  output logic            o_empty,
  output logic            o_full
);

  localparam int unsigned CNT_W = cnt_width(STACK_DEPTH);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned MEM_N = 1 << IDX_W;

  logic [PC_W-1:0]  r_mem [MEM_N];
  logic [CNT_W-1:0] r_count;
  logic [PC_W-1:0]  r_top;
  logic             r_empty;
  logic             r_full;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !r_full;
  assign w_do_pop  = i_pop && !r_empty && !i_push;
  assign w_wr_idx  = IDX_W'(r_count);
  // Entry that becomes the new top after a pop; its value is unused when the pop empties the stack.
  assign w_rd_idx  = IDX_W'(r_count - CNT_W'(2));

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
      r_top   <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else if (w_do_push) begin
      r_count <= r_count + CNT_W'(1);
      r_top   <= i_push_data;
      r_empty <= 1'b0;
      r_full  <= (r_count == CNT_W'(STACK_DEPTH - 1));
    end else if (w_do_pop) begin
      r_count <= r_count - CNT_W'(1);
      r_top   <= r_mem[w_rd_idx];
      r_empty <= (r_count == CNT_W'(1));
      r_full  <= 1'b0;
    end
  end

  assign o_top   = r_top;
  assign o_empty = r_empty;
  assign o_full  = r_full;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: increment, jump, call/return through pc_stack, plus halt and fault states.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned    PC_W        = 11,
  parameter int unsigned    STACK_DEPTH = DEF_STACK_DEPTH,
  parameter logic [PC_W-1:0] RESET_ADDR = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_enable,
  input  logic            i_halt,
  input  logic            i_jump,
  input  logic            i_call,
  input  logic            i_ret,
  input  logic [PC_W-1:0] i_target,
  output logic [PC_W-1:0] o_pc,
  output logic            o_halted,
  output logic            o_fault,
  output logic            o_stack_empty,
  output logic            o_stack_full
);

  pc_state_e       r_state;
  pc_state_e       w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_pc_inc;
  logic            r_halted;
  logic            r_fault;
  logic            w_push;
  logic            w_pop;
  logic [PC_W-1:0] w_top;
  logic            w_empty;
  logic            w_full;

  assign w_pc_inc = r_pc + PC_W'(1);

  pc_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (w_pc_inc),
    .o_top       (w_top),
    .o_empty     (w_empty),
    .o_full      (w_full)
  );

  // One action per enabled RUN cycle, priority halt > ret > call > jump > increment.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (i_enable) begin
          if (i_halt) begin
            w_state_nxt = ST_HALTED;
          end else if (i_ret) begin
            if (w_empty) begin
              w_state_nxt = ST_FAULT;
            end else begin
              w_pop    = 1'b1;
              w_pc_nxt = w_top;
            end
          end else if (i_call) begin
            if (w_full) begin
              w_state_nxt = ST_FAULT;
            end else begin
              w_push   = 1'b1;
              w_pc_nxt = i_target;
            end
          end else if (i_jump) begin
            w_pc_nxt = i_target;
          end else begin
            w_pc_nxt = w_pc_inc;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_RUN;
      r_pc     <= RESET_ADDR;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_halted <= (w_state_nxt == ST_HALTED);
      r_fault  <= (w_state_nxt == ST_FAULT);
    end
  end

  assign o_pc          = r_pc;
  assign o_halted      = r_halted;
  assign o_fault       = r_fault;
  assign o_stack_empty = w_empty;
  assign o_stack_full  = w_full;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (PC_W=11, STACK_DEPTH=4, RESET_ADDR=0).
module tb_pc_sequencer;

  localparam int unsigned PC_W = 11;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic            halt = 1'b0;
  logic            jump = 1'b0;
  logic            call = 1'b0;
  logic            ret = 1'b0;
  logic [PC_W-1:0] target = '0;
  logic [PC_W-1:0] pc;
  logic            halted;
  logic            fault;
  logic            s_empty;
  logic            s_full;

  int n_checks = 0;
  int n_errors = 0;

  pc_sequencer #(
    .PC_W        (PC_W),
    .STACK_DEPTH (4),
    .RESET_ADDR  (11'h000)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_enable      (en),
    .i_halt        (halt),
    .i_jump        (jump),
    .i_call        (call),
    .i_ret         (ret),
    .i_target      (target),
    .o_pc          (pc),
    .o_halted      (halted),
    .o_fault       (fault),
    .o_stack_empty (s_empty),
    .o_stack_full  (s_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [PC_W-1:0] e_pc, input logic e_halt,
                         input logic e_fault, input logic e_empty, input logic e_full);
    check({tag, ".pc"},     32'(pc),      32'(e_pc));
    check({tag, ".halted"}, 32'(halted),  32'(e_halt));
    check({tag, ".fault"},  32'(fault),   32'(e_fault));
    check({tag, ".empty"},  32'(s_empty), 32'(e_empty));
    check({tag, ".full"},   32'(s_full),  32'(e_full));
  endtask

  // Drive one cycle of commands, then sample just after the rising edge.
  task automatic cyc(input logic e, input logic h, input logic j, input logic c, input logic r,
                     input logic [PC_W-1:0] t);
    en = e; halt = h; jump = j; call = c; ret = r; target = t;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    en = 1'b0; halt = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 11'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;

    for (int i = 1; i <= 5; i++) begin
      cyc(1, 0, 0, 0, 0, 11'h000);
      check($sformatf("incr%0d", i), 32'(pc), 32'(i));
    end
    cyc(0, 0, 1, 0, 0, 11'h3AA);
    check("dis_jump", 32'(pc), 32'h5);
    cyc(0, 0, 0, 1, 0, 11'h3AA);
    chk_all("dis_call", 11'h005, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(0, 0, 0, 0, 0, 11'h000);
    check("dis_idle", 32'(pc), 32'h5);

    // Wrap-around and a call/return across it
    cyc(1, 0, 1, 0, 0, 11'h7FF);
    check("jump_7ff", 32'(pc), 32'h7FF);
    cyc(1, 0, 0, 0, 0, 11'h000);
    check("wrap", 32'(pc), 32'h000);
    cyc(1, 0, 0, 1, 0, 11'h7FF);
    chk_all("call_7ff", 11'h7FF, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1, 0, 0, 0, 0, 11'h000);
    check("wrap2", 32'(pc), 32'h000);
    cyc(1, 0, 0, 0, 1, 11'h000);
    chk_all("ret_001", 11'h001, 1'b0, 1'b0, 1'b1, 1'b0);

    // Nested calls to full depth, then unwind
    cyc(1, 0, 1, 0, 0, 11'h010);
    cyc(1, 0, 0, 1, 0, 11'h100);
    chk_all("call1", 11'h100, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1, 0, 0, 1, 0, 11'h200);
    cyc(1, 0, 0, 1, 0, 11'h300);
    chk_all("call3", 11'h300, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1, 0, 0, 1, 0, 11'h400);
    chk_all("call4", 11'h400, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1, 0, 0, 0, 1, 11'h000);
    chk_all("ret1", 11'h301, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1, 0, 0, 0, 1, 11'h000);
    check("ret2", 32'(pc), 32'h201);
    cyc(1, 0, 0, 0, 1, 11'h000);
    check("ret3", 32'(pc), 32'h101);
    cyc(1, 0, 0, 0, 1, 11'h000);
    chk_all("ret4", 11'h011, 1'b0, 1'b0, 1'b1, 1'b0);

    // Underflow fault is absorbing
    cyc(1, 0, 0, 0, 1, 11'h000);
    chk_all("ret_empty", 11'h011, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1, 0, 1, 0, 0, 11'h222);
    chk_all("fault_jump", 11'h011, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1, 1, 0, 0, 0, 11'h000);
    chk_all("fault_halt", 11'h011, 1'b0, 1'b1, 1'b1, 1'b0);
    apply_reset();
    chk_all("reset2", 11'h000, 1'b0, 1'b0, 1'b1, 1'b0);

    // Overflow fault on fifth call
    cyc(1, 0, 0, 1, 0, 11'h100);
    cyc(1, 0, 0, 1, 0, 11'h200);
    cyc(1, 0, 0, 1, 0, 11'h300);
    cyc(1, 0, 0, 1, 0, 11'h400);
    cyc(1, 0, 0, 1, 0, 11'h500);
    chk_all("call_full", 11'h400, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1, 0, 0, 0, 1, 11'h000);
    chk_all("fault_ret", 11'h400, 1'b0, 1'b1, 1'b0, 1'b1);
    apply_reset();
    chk_all("reset3", 11'h000, 1'b0, 1'b0, 1'b1, 1'b0);

    // call+ret in the same cycle: ret wins
    cyc(1, 0, 1, 0, 0, 11'h01F);
    cyc(1, 0, 0, 1, 0, 11'h123);
    chk_all("call_123", 11'h123, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1, 0, 0, 1, 1, 11'h555);
    chk_all("call_ret", 11'h020, 1'b0, 1'b0, 1'b1, 1'b0);

    // halt+jump+call in the same cycle: halt wins, stack untouched
    cyc(1, 0, 0, 1, 0, 11'h040);
    chk_all("call_040", 11'h040, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1, 1, 1, 1, 0, 11'h300);
    chk_all("halt", 11'h040, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1, 0, 0, 0, 1, 11'h000);
    chk_all("halt_ret", 11'h040, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_reset();
    chk_all("reset4", 11'h000, 1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset between edges with two entries and a call pending
    cyc(1, 0, 0, 1, 0, 11'h100);
    cyc(1, 0, 0, 1, 0, 11'h200);
    chk_all("two_deep", 11'h200, 1'b0, 1'b0, 1'b0, 1'b0);
    en = 1'b1; call = 1'b1; target = 11'h333;
    #3;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 11'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    call = 1'b0;
    #1;
    rst = 1'b0;
    cyc(1, 0, 0, 0, 0, 11'h000);
    chk_all("after_rst", 11'h001, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
